// File: rtl/slow_memory_param_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : slow_memory_param_if                                             |
// | Purpose : Line-memory request/response bus. SLOW_MEM_WMASK_EN adds the     |
// |           per-word write mask signal.                                      |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
interface slow_memory_param_if #(
  parameter int ADDR_WIDTH = 28,
  parameter int MEM_WIDTH  = 128
`ifdef SLOW_MEM_WMASK_EN
  ,
  parameter int WORDS_PER_LINE = 4
`endif
);
  logic                  mem_read;
  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [MEM_WIDTH-1:0]  mem_wdata;
`ifdef SLOW_MEM_WMASK_EN
  logic [WORDS_PER_LINE-1:0] mem_wmask;
`endif
  logic [MEM_WIDTH-1:0]  mem_rdata;
  logic                  mem_ready;
  logic                  mem_err;

  modport master (
    output mem_read, mem_write, mem_addr, mem_wdata,
`ifdef SLOW_MEM_WMASK_EN
    output mem_wmask,
`endif
    input  mem_rdata, mem_ready, mem_err
  );

  modport slave (
    input  mem_read, mem_write, mem_addr, mem_wdata,
`ifdef SLOW_MEM_WMASK_EN
    input  mem_wmask,
`endif
    output mem_rdata, mem_ready, mem_err
  );
endinterface
`default_nettype wire

// File: rtl/slow_memory_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : slow_memory_param                                                |
// | Purpose : Cycle-counted line memory, one read/write at a time, with range  |
// |           error. Optional per-word write mask under SLOW_MEM_WMASK_EN.     |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module slow_memory_param #(
  parameter int MEM_NUM        = 64,
  parameter int WORD_WIDTH     = 32,
  parameter int WORDS_PER_LINE = 4,
  parameter int ADDR_WIDTH     = 28,
  parameter int LATENCY        = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  slow_memory_param_if.slave mem_if
);

  localparam int MEM_WIDTH = WORD_WIDTH * WORDS_PER_LINE;
  localparam int c_IDX_W   = (MEM_NUM > 1) ? $clog2(MEM_NUM) : 1;
  localparam logic [7:0]          c_CNT_LOAD = 8'(LATENCY - 1);
  localparam logic [ADDR_WIDTH:0] c_MEM_NUM  = (ADDR_WIDTH + 1)'(MEM_NUM);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t                  state_q;
  logic [7:0]              cnt_q;
  logic                    wr_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [MEM_WIDTH-1:0]    wdata_q;
  logic [MEM_WIDTH-1:0]    rdata_q;
  logic                    ready_q;
  logic                    err_q;
  logic [MEM_WIDTH-1:0]    mem_q [MEM_NUM];

  logic                    w_oob;
  logic [c_IDX_W-1:0]      w_idx;
  logic                    w_done;
  logic                    w_commit;
  logic                    w_req_rd;
  logic                    w_req_wr;
  logic [WORDS_PER_LINE-1:0] w_wmask;

`ifdef SLOW_MEM_WMASK_EN
  logic [WORDS_PER_LINE-1:0] wmask_q;
  assign w_wmask = wmask_q;
`else
  assign w_wmask = '1;
`endif

  // Range check runs on the full captured address so the index truncation below is safe.
  assign w_oob    = ({1'b0, addr_q} >= c_MEM_NUM);
  assign w_idx    = addr_q[c_IDX_W-1:0];
  assign w_done   = (state_q == S_WAIT) && (cnt_q == 8'd0);
  assign w_commit = w_done && wr_q && !w_oob;
  assign w_req_rd = mem_if.mem_read  & ~mem_if.mem_write;
  assign w_req_wr = mem_if.mem_write & ~mem_if.mem_read;

  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int i = 0; i < WORDS_PER_LINE; i++) begin
        if (w_wmask[i]) begin
          mem_q[w_idx][i*WORD_WIDTH +: WORD_WIDTH] <= wdata_q[i*WORD_WIDTH +: WORD_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
`ifdef SLOW_MEM_WMASK_EN
      wmask_q <= '0;
`endif
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (w_req_rd || w_req_wr) begin
            wr_q    <= w_req_wr;
            addr_q  <= mem_if.mem_addr;
            wdata_q <= mem_if.mem_wdata;
`ifdef SLOW_MEM_WMASK_EN
            wmask_q <= mem_if.mem_wmask;
`endif
            cnt_q   <= c_CNT_LOAD;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_q == 8'd0) begin
            state_q <= S_RESP;
            ready_q <= 1'b1;
            err_q   <= w_oob;
            if (!wr_q) begin
              rdata_q <= w_oob ? '0 : mem_q[w_idx];
            end
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        // GAP gives the requester a cycle to drop a request held through ready.
        S_RESP:  state_q <= S_GAP;
        S_GAP:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_if.mem_rdata = rdata_q;
  assign mem_if.mem_ready = ready_q;
  assign mem_if.mem_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_slow_memory_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_slow_memory_param                                             |
// | Purpose : Directed bench for slow_memory_param (default parameters);       |
// |           mask steps run when SLOW_MEM_WMASK_EN is defined.                |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_slow_memory_param;

  localparam int LAT = 8;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  slow_memory_param_if #(
    .ADDR_WIDTH(28),
    .MEM_WIDTH (128)
`ifdef SLOW_MEM_WMASK_EN
    ,
    .WORDS_PER_LINE(4)
`endif
  ) bus ();

  slow_memory_param #(
    .MEM_NUM       (64),
    .WORD_WIDTH    (32),
    .WORDS_PER_LINE(4),
    .ADDR_WIDTH    (28),
    .LATENCY       (LAT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mem_if(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Capture happens at edge t0; ready must be seen only after edge t0+LAT.
  task automatic txn(input string tag, input logic wr, input logic [27:0] a,
                     input logic [127:0] d, input logic [127:0] exp_rd,
                     input logic exp_err, input bit hold);
    @(negedge clk);
    bus.mem_read  = !wr;
    bus.mem_write = wr;
    bus.mem_addr  = a;
    bus.mem_wdata = d;
    @(posedge clk);
    for (int k = 0; k <= LAT + 1; k++) begin
      @(negedge clk);
      check($sformatf("%s ready k=%0d", tag, k), 128'(bus.mem_ready), 128'(k == LAT));
      if (k == LAT) begin
        check({tag, " err"},   128'(bus.mem_err), 128'(exp_err));
        check({tag, " rdata"}, bus.mem_rdata, exp_rd);
        if (!hold) begin
          bus.mem_read  = 1'b0;
          bus.mem_write = 1'b0;
        end
      end
    end
  endtask

  localparam logic [127:0] D0 = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
  localparam logic [127:0] D1 = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] D2 = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
  localparam logic [127:0] D3 = 128'h63636363_00000063_CAFEF00D_12345678;
  localparam logic [127:0] DA = 128'hAAAAAAAA_AAAAAAAA_AAAAAAAA_AAAAAAAA;
  localparam logic [127:0] DB = 128'hBBBBBBBB_BBBBBBBB_BBBBBBBB_BBBBBBBB;

  logic seen;

  initial begin
    rst_n         = 1'b0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
`ifdef SLOW_MEM_WMASK_EN
    bus.mem_wmask = 4'b1111;
`endif
    repeat (2) @(negedge clk);
    check("reset ready", 128'(bus.mem_ready), 128'(0));
    check("reset err",   128'(bus.mem_err),   128'(0));
    check("reset rdata", bus.mem_rdata,       128'(0));
    rst_n = 1'b1;

    txn("wr0",  1'b1, 28'd0,  D0, 128'(0), 1'b0, 1'b0);
    txn("wr5",  1'b1, 28'd5,  D1, 128'(0), 1'b0, 1'b0);
    txn("rd5",  1'b0, 28'd5,  '0, D1,      1'b0, 1'b0);
    txn("wr7",  1'b1, 28'd7,  DA, D1,      1'b0, 1'b0);
    txn("wr63", 1'b1, 28'd63, D3, D1,      1'b0, 1'b0);

    // Conflicting request must never be served.
    @(negedge clk);
    bus.mem_read  = 1'b1;
    bus.mem_write = 1'b1;
    bus.mem_addr  = 28'd7;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      seen = seen | bus.mem_ready;
    end
    check("both-high no ready", 128'(seen), 128'(0));
    txn("rd7 after both", 1'b0, 28'd7, '0, DA, 1'b0, 1'b0);

    txn("wr64 oob", 1'b1, 28'd64, D2, DA,      1'b1, 1'b0);
    txn("rd64 oob", 1'b0, 28'd64, '0, 128'(0), 1'b1, 1'b0);
    txn("rd0 kept", 1'b0, 28'd0,  '0, D0,      1'b0, 1'b0);
    txn("rd63",     1'b0, 28'd63, '0, D3,      1'b0, 1'b0);

    // Read held through ready and GAP, then a new read issued right after GAP.
    txn("rd5 hold",     1'b0, 28'd5, '0, D1, 1'b0, 1'b1);
    txn("rd7 after gap", 1'b0, 28'd7, '0, DA, 1'b0, 1'b0);

    // Reset three cycles into a write of line 7.
    @(negedge clk);
    bus.mem_write = 1'b1;
    bus.mem_addr  = 28'd7;
    bus.mem_wdata = DB;
    @(posedge clk);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort ready", 128'(bus.mem_ready), 128'(0));
    check("abort err",   128'(bus.mem_err),   128'(0));
    check("abort rdata", bus.mem_rdata,       128'(0));
    @(negedge clk);
    bus.mem_write = 1'b0;
    seen = bus.mem_ready;
    repeat (LAT + 2) begin
      @(negedge clk);
      seen = seen | bus.mem_ready;
    end
    check("abort no ready", 128'(seen), 128'(0));
    rst_n = 1'b1;
    txn("rd7 after abort", 1'b0, 28'd7, '0, DA, 1'b0, 1'b0);

`ifdef SLOW_MEM_WMASK_EN
    bus.mem_wmask = 4'b1111;
    txn("wr2 ones", 1'b1, 28'd2, '1, DA, 1'b0, 1'b0);
    bus.mem_wmask = 4'b0101;
    txn("wr2 mask", 1'b1, 28'd2, '0, DA, 1'b0, 1'b0);
    bus.mem_wmask = 4'b0000;
    txn("wr2 nomask", 1'b1, 28'd2, D2, DA, 1'b0, 1'b0);
    bus.mem_wmask = 4'b0000;
    txn("rd2 mask", 1'b0, 28'd2, '0,
        128'hFFFFFFFF_00000000_FFFFFFFF_00000000, 1'b0, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
